if_id_pipe_reg_tmr: RTL and testbench

- IF/ID pipeline register with triple modular redundancy (TMR). It is the consumer of the IF_ID_Flush signal from the branch/jump hazard unit and of the stall signal from the load-use hazard unit.
- Holds PC+4, the instruction and a valid bit in three redundant copies, and presents the bitwise majority vote to the ID stage.
- Scrubs single-copy upsets on every hold cycle. Counts detected copy disagreements for fault reporting.

---
 rtl/if_id_pipe_reg_tmr.sv | 45 ++++
 tb/tb_if_id_pipe_reg_tmr.sv | 124 ++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg_tmr.sv
// if_id_pipe_reg_tmr: triple-redundant IF/ID pipeline register with voted outputs, scrub-on-stall and an upset counter
module if_id_pipe_reg_tmr #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             valid_in,
  input  logic [PC_W-1:0]  pc_plus4_in,
  input  logic [31:0]      instr_in,
  input  logic             inj_en,
  input  logic [1:0]       inj_sel,
  input  logic [31:0]      inj_mask,
  output logic             valid_out,
  output logic [PC_W-1:0]  pc_plus4_out,
  output logic [31:0]      instr_out,
  output logic             err_now,
  output logic [CNT_W-1:0] err_count
);
  localparam int W = PC_W + 33;
  logic [W-1:0] c0, c1, c2, v, n, m, m0, m1, m2;
  logic inj;
  // Vote, pick the shared next value (stall rewrites the vote, which scrubs), and build the per-copy upset masks
  always_comb begin
    v = (c0 & c1) | (c1 & c2) | (c0 & c2);
    n = (rst || flush) ? {1'b0, {PC_W{1'b0}}, NOP_INSTR} : stall ? v : {valid_in, pc_plus4_in, instr_in};
    inj = inj_en && !rst;
    m = {{(PC_W + 1){1'b0}}, inj_mask};
    m0 = (inj && inj_sel == 2'd0) ? m : '0;
    m1 = (inj && inj_sel == 2'd1) ? m : '0;
    m2 = (inj && inj_sel == 2'd2) ? m : '0;
    {valid_out, pc_plus4_out, instr_out} = v;
    err_now = (c0 != c1) || (c1 != c2) || (c0 != c2);
  end
  // All copies load the same next value; the upset counter saturates at all-ones
  always_ff @(posedge clk) begin
    c0 <= n ^ m0;
    c1 <= n ^ m1;
    c2 <= n ^ m2;
    err_count <= rst ? '0 : (err_now && !(&err_count)) ? err_count + CNT_W'(1) : err_count;
  end
endmodule

// File: tb/tb_if_id_pipe_reg_tmr.sv
// tb_if_id_pipe_reg_tmr: scoreboard bench comparing the TMR IF/ID register against an architectural-value-plus-upset-mask model
module tb_if_id_pipe_reg_tmr;
  logic clk = 0;
  logic rst = 1, flush = 0, stall = 0, valid_in = 0, inj_en = 0;
  logic [31:0] pc_plus4_in = 0, instr_in = 0, inj_mask = 0;
  logic [1:0] inj_sel = 2'd3;
  logic valid_out, err_now, d2_valid, d2_err;
  logic [31:0] pc_plus4_out, instr_out, d2_pc, d2_instr;
  logic [7:0] err_count;
  logic [1:0] d2_count;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  if_id_pipe_reg_tmr dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .valid_in(valid_in),
    .pc_plus4_in(pc_plus4_in), .instr_in(instr_in), .inj_en(inj_en), .inj_sel(inj_sel),
    .inj_mask(inj_mask), .valid_out(valid_out), .pc_plus4_out(pc_plus4_out),
    .instr_out(instr_out), .err_now(err_now), .err_count(err_count));

  if_id_pipe_reg_tmr #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .valid_in(valid_in),
    .pc_plus4_in(pc_plus4_in), .instr_in(instr_in), .inj_en(inj_en), .inj_sel(inj_sel),
    .inj_mask(inj_mask), .valid_out(d2_valid), .pc_plus4_out(d2_pc),
    .instr_out(d2_instr), .err_now(d2_err), .err_count(d2_count));

  typedef struct {
    logic v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic e;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;
  exp_t q[$];

  // Model: the architecturally correct register value, plus an XOR upset mask per copy
  logic        a_v;
  logic [31:0] a_pc, a_ins;
  logic [31:0] e[3];
  int          cnt;

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (int'(x[i]) + int'(y[i]) + int'(z[i])) >= 2;
    return r;
  endfunction

  function automatic logic disagree();
    return (e[0] != e[1]) || (e[1] != e[2]) || (e[0] != e[2]);
  endfunction

  task automatic cyc(input logic r, f, s, vi, input logic [31:0] pc, ins,
                     input logic ie, input logic [1:0] sel, input logic [31:0] msk);
    exp_t x;
    logic [31:0] vins;
    @(negedge clk);
    rst = r; flush = f; stall = s; valid_in = vi; pc_plus4_in = pc; instr_in = ins;
    inj_en = ie; inj_sel = sel; inj_mask = msk;
    if (r) cnt = 0;
    else if (disagree()) cnt++;
    vins = a_ins ^ maj(e[0], e[1], e[2]);
    if (r || f) begin a_v = 0; a_pc = 0; a_ins = 32'h0; end
    else if (s) a_ins = vins;
    else begin a_v = vi; a_pc = pc; a_ins = ins; end
    for (int i = 0; i < 3; i++) e[i] = (!r && ie && sel == 2'(i)) ? msk : 32'h0;
    x.v = a_v; x.pc = a_pc; x.ins = a_ins ^ maj(e[0], e[1], e[2]); x.e = disagree();
    x.c8 = cnt > 255 ? 8'd255 : 8'(cnt);
    x.c2 = cnt > 3 ? 2'd3 : 2'(cnt);
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: each edge the DUT presents a new register state, compared against the oldest pending expectation
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("valid_out", 32'(valid_out), 32'(x.v));
      chk("pc_plus4_out", pc_plus4_out, x.pc);
      chk("instr_out", instr_out, x.ins);
      chk("err_now", 32'(err_now), 32'(x.e));
      chk("err_count", 32'(err_count), 32'(x.c8));
      chk("err_count_w2", 32'(d2_count), 32'(x.c2));
    end
  end

  initial begin
    a_v = 0; a_pc = 0; a_ins = 0; cnt = 0;
    for (int i = 0; i < 3; i++) e[i] = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 3, 0);
    cyc(0, 0, 0, 1, 32'h104, 32'h8C220004, 0, 3, 0);
    repeat (3) cyc(0, 0, 1, 1, 32'h108, 32'h00430820, 0, 3, 0);
    cyc(0, 0, 0, 1, 32'h108, 32'h00430820, 0, 3, 0);
    cyc(0, 0, 0, 1, 32'h104, 32'h8C220004, 0, 3, 0);
    cyc(0, 1, 1, 1, 32'h108, 32'h00430820, 0, 3, 0);
    cyc(0, 0, 0, 1, 32'h104, 32'h8C220004, 0, 3, 0);
    cyc(0, 0, 1, 1, 32'h108, 32'h00430820, 1, 1, 32'h1);
    repeat (2) cyc(0, 0, 1, 1, 32'h108, 32'h00430820, 0, 3, 0);
    cyc(0, 0, 1, 1, 32'h108, 32'h00430820, 1, 0, 32'h10);
    cyc(0, 0, 1, 1, 32'h108, 32'h00430820, 1, 2, 32'h10);
    cyc(0, 0, 1, 1, 32'h108, 32'h00430820, 0, 3, 0);
    repeat (6) cyc(0, 0, 1, 1, 32'h108, 32'h00430820, 1, 0, 32'hFFFFFFFF);
    repeat (260) cyc(0, 0, 1, 0, 32'h0, 32'h0, 1, 0, 32'hFFFFFFFF);
    cyc(0, 1, 0, 1, 32'h200, 32'h12345678, 1, 2, 32'hF0F0F0F0);
    cyc(1, 1, 1, 1, 32'h204, 32'h11111111, 1, 1, 32'hFFFFFFFF);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
          1'($urandom), $urandom, $urandom, $urandom_range(0, 3) == 0,
          2'($urandom_range(0, 3)), $urandom);
    cyc(0, 0, 0, 0, 0, 0, 0, 3, 0);
    repeat (2) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
